bcd_score_encoder: RTL
======================

// Module: bcd_score_encoder
// PURPOSE
//  Sequential binary-to-BCD encoder (shift-add-3 / double-dabble) feeding per-digit
//  7-seg decoders. Takes a binary score/count on a start strobe and iterates one bit
//  per clock. Presents DIGITS registered BCD nibbles, with optional leading-zero
//  blanking via code 4'hF (the decoders' "display nothing" code).
// PARAMETERS
//  BIN_W   14  width of binary input; range 0..2^BIN_W-1
//  DIGITS  4   number of BCD digits produced; max displayable MAXV = 10^DIGITS-1
// PORTS
//  clk      in   1           system clock; all state on posedge
//  reset    in   1           synchronous, active-low reset (sampled on posedge clk)
//  start    in   1           request conversion of bin; accepted only in IDLE
//  bin      in   BIN_W       binary value; sampled on the accepting cycle only
//  busy     out  1           high while a conversion is in progress
//  done     out  1           one-cycle pulse: bcd/ovf just updated
//  ovf      out  1           last accepted bin exceeded MAXV (held until next done)
//  bcd      out  4*DIGITS    digit i at [4i+3:4i], digit 0 = least significant
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; busy=0, done=0, ovf=0, bcd=all 4'h0.
//    Takes effect mid-conversion; the partial result is discarded, no done pulse.
//  - FSM: IDLE -> SHIFT on start; SHIFT -> FINISH after BIN_W shifts; FINISH -> IDLE.
//  - Accept: start=1 in IDLE at edge t captures bin into shift reg, clears BCD
//    accumulator, bit counter=BIN_W-1. busy=1 on cycles t+1 .. t+BIN_W.
//  - SHIFT, each cycle: every accumulator nibble >=5 gets +3 (combinational), then
//    {acc,shreg} shifts left 1 bit, MSB first. Counter decrements; leaves at 0.
//  - FINISH: bcd register loaded, ovf updated, done=1 exactly one cycle (t+BIN_W+1).
//    busy=0 in FINISH. Fixed latency start->done = BIN_W+1 cycles for every input.
//  - Overflow: bin>MAXV is decided at capture; conversion still runs full latency;
//    at FINISH bcd = all 4'h9, ovf=1. Otherwise ovf=0.
//  - start while busy or in FINISH: ignored, not queued. start=1 in IDLE the cycle
//    after done: accepted normally (back-to-back period BIN_W+2).
//  - bcd/ovf change only at FINISH or reset; stable otherwise (safe for display).
//  - Accumulator width 4*DIGITS; bits shifted beyond it are dropped (only reachable
//    on overflow, masked by saturation).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: at FINISH, every digit above the most significant
//    non-zero digit is replaced by 4'hF; digit 0 is never blanked (value 0 -> "   0").
//    Overflow saturation (all 9s) is not blanked.
//  Not defined: all DIGITS nibbles are raw BCD 0..9, including leading zeros.
// STRUCTURE
//  Package disp_pkg: localparam logic [3:0] BCD_BLANK = 4'hF; BCD_NINE = 4'h9;
//    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} bcd_enc_state_t;
//    typedef logic [3:0] bcd_digit_t.
//  Sub-module dabble_adj: 4-bit combinational add-3-if->=5 cell, one instance per
//    digit via generate. FSM, counter, shift reg, blanking logic live in top module.
// TESTING
//  1 reset low 2 cycles, release -> busy=0, done=0, ovf=0, bcd=16'h0000.
//  2 bin=1234, start 1 cycle -> busy 14 cycles, done at +15, bcd=16'h1234, ovf=0.
//  3 bin=0 -> bcd=16'h0000 (blank off) / 16'hFFF0 (LEADING_ZERO_BLANK_EN);
//    bin=7 -> 16'h0007 / 16'hFFF7; bin=9999 -> 16'h9999 both builds.
//  4 bin=10000 -> done at +15, bcd=16'h9999, ovf=1; next bin=42 -> ovf=0, bcd=0042/FF42.
//  5 start=1 held with bin changing at cycles +3,+8 -> only first value converted;
//    new conversion accepted on cycle after done (period 16).
//  6 reset low at SHIFT cycle 6 of bin=5555 -> no done pulse, bcd=0000; next start
//    with bin=321 -> bcd=16'h0321 (16'hF321 with blanking) after 15 cycles.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared display constants, state encoding and digit type for the BCD score encoder.
package disp_pkg;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE = 4'h9;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} bcd_enc_state_t;
  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/dabble_adj.sv
// dabble_adj: add-3-if->=5 correction for one BCD digit ahead of a double-dabble shift.
import disp_pkg::*;
module dabble_adj (
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_score_encoder.sv
// bcd_score_encoder: sequential binary-to-BCD converter, one bit per clock, saturating to all 9s.
// Define LEADING_ZERO_BLANK_EN to replace leading zero digits with the blank code.
import disp_pkg::*;
module bcd_score_encoder #(
  parameter int BIN_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam longint MAXV = longint'(10**DIGITS) - 1;
  bcd_enc_state_t state, next_state;
  logic [BIN_W-1:0] shreg;
  logic [AW-1:0] acc, adj, acc_next, result;
  logic [CW-1:0] cnt;
  logic sat;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      dabble_adj u_adj (.d(acc[4*g+:4]), .q(adj[4*g+:4]));
    end
  endgenerate
  // Top accumulator bit falls off; only reachable on overflow, which saturates anyway.
  assign acc_next = {adj[AW-2:0], shreg[BIN_W-1]};
  assign busy = state == SHIFT;
  assign done = state == FINISH;
  always_comb begin
    next_state = state == IDLE  ? (start ? SHIFT : IDLE) :
                 state == SHIFT ? (cnt == '0 ? FINISH : SHIFT) : IDLE;
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    result = sat ? {DIGITS{BCD_NINE}} : acc_next;
    lead = !sat;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && result[4*i+:4] == 4'h0) result[4*i+:4] = BCD_BLANK;
      else lead = 1'b0;
    end
  end
`else
  always_comb begin
    result = sat ? {DIGITS{BCD_NINE}} : acc_next;
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  // bcd/ovf load on the final shift edge so they are valid throughout the done cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      shreg <= bin;
      acc <= '0;
      cnt <= CW'(BIN_W - 1);
      sat <= longint'(bin) > MAXV;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        bcd <= result;
        ovf <= sat;
      end
    end
  end
endmodule
